// File: rtl/imm_exec_pkg.sv
// Shared definitions for the imm_exec controller: opcodes, ALU ops,
// FSM states, instruction field positions and the decoded control word.
package imm_exec_pkg;

  localparam int DATA_W = 8;
  localparam int IMM_W  = 3;
  localparam int RA_W   = 2;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_LDI  = 3'b110;
  localparam logic [2:0] OP_HLT  = 3'b111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_AND   = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 5;
  localparam int RD_MSB  = 4;
  localparam int RD_LSB  = 3;
  localparam int IMM_MSB = 2;
  localparam int IMM_LSB = 0;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic [RA_W-1:0]  rd;
    logic [RA_W-1:0]  rs;
    logic [IMM_W-1:0] imm;
    logic             src_imm;
    logic [1:0]       alu_op;
    logic             sext;
  } ctrl_t;

endpackage

// File: rtl/imm_exec_decode.sv
// Combinational opcode-to-control-word decoder.
// IMM_SIGN_EXT_EN: request signed immediates for ADDI/SUBI.
module imm_exec_decode
  import imm_exec_pkg::*;
(
  input  logic [DATA_W-1:0] instr_i,
  output ctrl_t             ctrl_o,
  output logic              nop_o,
  output logic              hlt_o
);

`ifdef IMM_SIGN_EXT_EN
  localparam logic SEXT_EN = 1'b1;
`else
  localparam logic SEXT_EN = 1'b0;
`endif

  logic [2:0] op;
  assign op = instr_i[OP_MSB:OP_LSB];

  always_comb begin
    ctrl_o         = '0;
    ctrl_o.rd      = instr_i[RD_MSB:RD_LSB];
    ctrl_o.rs      = instr_i[RS_MSB:RS_LSB];
    ctrl_o.imm     = instr_i[IMM_MSB:IMM_LSB];
    ctrl_o.alu_op  = ALU_ADD;
    nop_o          = 1'b0;
    hlt_o          = 1'b0;
    unique case (1'b1)
      op == OP_NOP: nop_o = 1'b1;
      op == OP_ADD: ctrl_o.alu_op = ALU_ADD;
      op == OP_SUB: ctrl_o.alu_op = ALU_SUB;
      op == OP_ADDI: begin
        ctrl_o.src_imm = 1'b1;
        ctrl_o.alu_op  = ALU_ADD;
        ctrl_o.sext    = SEXT_EN;
      end
      op == OP_SUBI: begin
        ctrl_o.src_imm = 1'b1;
        ctrl_o.alu_op  = ALU_SUB;
        ctrl_o.sext    = SEXT_EN;
      end
      op == OP_AND: ctrl_o.alu_op = ALU_AND;
      op == OP_LDI: begin
        ctrl_o.src_imm = 1'b1;
        ctrl_o.alu_op  = ALU_PASSB;
      end
      op == OP_HLT: hlt_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_exec_ctrl.sv
// Multi-cycle fetch/decode/exec/writeback controller for the 8-bit core.
// IMM_SIGN_EXT_EN (in imm_exec_decode) enables imm_sext_o for ADDI/SUBI.
module imm_exec_ctrl
  import imm_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid_i,
  input  logic [DATA_W-1:0] instr_i,
  output logic              instr_ready_o,
  input  logic              stall_i,
  input  logic              resume_i,
  output logic              pc_inc_o,
  output logic [IMM_W-1:0]  imm_field_o,
  output logic              alu_src_imm_o,
  output logic [1:0]        alu_op_o,
  output logic              alu_en_o,
  output logic [RA_W-1:0]   rd_addr_o,
  output logic [RA_W-1:0]   rs_addr_o,
  output logic              reg_we_o,
  output logic              halted_o,
  output logic              imm_sext_o
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] instr_q;
  ctrl_t             ctrl_q, ctrl_d;
  logic              dec_nop, dec_hlt;
  logic              accept;

  imm_exec_decode u_dec (
    .instr_i (instr_q),
    .ctrl_o  (ctrl_d),
    .nop_o   (dec_nop),
    .hlt_o   (dec_hlt)
  );

  assign accept = rst_n && (state_q == ST_FETCH) && instr_valid_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      instr_q <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        instr_q <= instr_i;
      if (state_q == ST_DECODE)
        ctrl_q <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH:  if (accept) state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec_nop)      state_d = ST_FETCH;
        else if (dec_hlt) state_d = ST_HALT;
        else              state_d = ST_EXEC;
      end
      ST_EXEC:   if (!stall_i) state_d = ST_WB;
      ST_WB:     if (!stall_i) state_d = ST_FETCH;
      ST_HALT:   if (resume_i) state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Strobes are gated by rst_n so a reset cycle never commits work.
  assign instr_ready_o = (state_q == ST_FETCH);
  assign pc_inc_o      = accept;
  assign alu_en_o      = rst_n && (state_q == ST_EXEC) && !stall_i;
  assign reg_we_o      = rst_n && (state_q == ST_WB) && !stall_i;
  assign halted_o      = (state_q == ST_HALT);

  assign imm_field_o   = ctrl_q.imm;
  assign alu_src_imm_o = ctrl_q.src_imm;
  assign alu_op_o      = ctrl_q.alu_op;
  assign rd_addr_o     = ctrl_q.rd;
  assign rs_addr_o     = ctrl_q.rs;
  assign imm_sext_o    = ctrl_q.sext;

endmodule

// File: tb/tb_imm_exec_ctrl.sv
// Self-checking bench for imm_exec_ctrl: directed steps plus random
// instructions checked against a transaction-level timing/decode model.
module tb_imm_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = '0;
  logic       stall = 1'b0;
  logic       resume = 1'b0;
  logic       instr_ready, pc_inc, alu_src_imm, alu_en;
  logic       reg_we, halted, imm_sext;
  logic [2:0] imm_field;
  logic [1:0] alu_op, rd_addr, rs_addr;

  int ncmp = 0;
  int nerr = 0;

  // Opcode-indexed tables straight from the instruction set
  logic [7:0] src_tbl = 8'b0101_1000;
  logic [1:0] alu_tbl [8] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`ifdef IMM_SIGN_EXT_EN
  logic [7:0] sext_tbl = 8'b0001_1000;
`else
  logic [7:0] sext_tbl = 8'b0000_0000;
`endif

  imm_exec_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid_i (instr_valid),
    .instr_i       (instr),
    .instr_ready_o (instr_ready),
    .stall_i       (stall),
    .resume_i      (resume),
    .pc_inc_o      (pc_inc),
    .imm_field_o   (imm_field),
    .alu_src_imm_o (alu_src_imm),
    .alu_op_o      (alu_op),
    .alu_en_o      (alu_en),
    .rd_addr_o     (rd_addr),
    .rs_addr_o     (rs_addr),
    .reg_we_o      (reg_we),
    .halted_o      (halted),
    .imm_sext_o    (imm_sext)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fields(input logic [7:0] ins);
    int op;
    op = int'(ins[7:5]);
    chk("rd_addr", 32'(rd_addr), 32'(ins[4:3]));
    chk("rs_addr", 32'(rs_addr), 32'(ins[1:0]));
    chk("imm_field", 32'(imm_field), 32'(ins[2:0]));
    chk("alu_src_imm", 32'(alu_src_imm), 32'(src_tbl[op]));
    chk("alu_op", 32'(alu_op), 32'(alu_tbl[op]));
    chk("imm_sext", 32'(imm_sext), 32'(sext_tbl[op]));
  endtask

  // Accept one instruction; sx/sw = stall cycles in EXEC/WB.
  task automatic run_instr(input logic [7:0] ins, input int sx,
                           input int sw);
    int  ta, tw, tend;
    bit  busy;
    busy = (ins[7:5] != 3'b000);
    ta   = 2 + sx;
    tw   = 3 + sx + sw;
    tend = busy ? 4 + sx + sw : 2;
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = ins;
    stall       = 1'($urandom % 2);
    resume      = 1'b0;
    #1;
    chk("ready_at_accept", 32'(instr_ready), 32'd1);
    chk("pc_inc_at_accept", 32'(pc_inc), 32'd1);
    chk("alu_en_at_accept", 32'(alu_en), 32'd0);
    chk("reg_we_at_accept", 32'(reg_we), 32'd0);
    chk("halted_at_accept", 32'(halted), 32'd0);
    for (int t = 1; t < tend; t++) begin
      @(negedge clk);
      instr_valid = 1'($urandom % 2);
      instr       = 8'($urandom);
      if (t == 1) stall = 1'($urandom % 2);
      else        stall = (t < ta) || (t > ta && t < tw);
      #1;
      chk("pc_inc_busy", 32'(pc_inc), 32'd0);
      chk("ready_busy", 32'(instr_ready), 32'd0);
      chk("alu_en", 32'(alu_en), 32'(busy && t == ta));
      chk("reg_we", 32'(reg_we), 32'(busy && t == tw));
      chk("halted_busy", 32'(halted), 32'd0);
      if (t >= 2) chk_fields(ins);
    end
  endtask

  // Accept HLT, stay halted k cycles, then resume (with stall also high).
  task automatic run_hlt(input logic [7:0] ins, input int k);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = ins;
    resume      = 1'b0;
    #1;
    chk("hlt_ready_at_accept", 32'(instr_ready), 32'd1);
    chk("hlt_pc_inc", 32'(pc_inc), 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    chk("hlt_decode_halted", 32'(halted), 32'd0);
    chk("hlt_decode_ready", 32'(instr_ready), 32'd0);
    for (int t = 0; t < k; t++) begin
      @(negedge clk);
      instr_valid = 1'b1;
      instr       = 8'($urandom);
      stall       = 1'($urandom % 2);
      #1;
      chk("halted", 32'(halted), 32'd1);
      chk("halt_ready", 32'(instr_ready), 32'd0);
      chk("halt_pc_inc", 32'(pc_inc), 32'd0);
      chk("halt_alu_en", 32'(alu_en), 32'd0);
      chk("halt_reg_we", 32'(reg_we), 32'd0);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    resume      = 1'b1;
    stall       = 1'b1;
    #1;
    chk("halted_at_resume", 32'(halted), 32'd1);
    @(negedge clk);
    resume = 1'b0;
    stall  = 1'b0;
    #1;
    chk("ready_after_resume", 32'(instr_ready), 32'd1);
    chk("halted_after_resume", 32'(halted), 32'd0);
  endtask

  initial begin
    logic [7:0] ins;
    // Reset held two clocks with valid high
    rst_n       = 1'b0;
    instr_valid = 1'b1;
    instr       = 8'b011_10_101;
    @(negedge clk);
    #1;
    chk("rst_pc_inc0", 32'(pc_inc), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_pc_inc1", 32'(pc_inc), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_alu_en", 32'(alu_en), 32'd0);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk_fields(8'h00);
    @(negedge clk);
    rst_n       = 1'b1;
    instr_valid = 1'b0;
    #1;
    chk("post_rst_ready", 32'(instr_ready), 32'd1);
    chk("post_rst_pc_inc", 32'(pc_inc), 32'd0);

    // Directed steps
    run_instr(8'b011_10_101, 0, 0);
    run_instr(8'b001_01_011, 3, 0);
    run_instr(8'b000_00_000, 0, 0);
    run_instr(8'b110_00_111, 0, 0);
    run_hlt(8'b111_00_000, 3);
    run_instr(8'b100_11_100, 1, 2);

    // Reset asserted during WB aborts the write
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = 8'b001_11_010;
    stall       = 1'b0;
    #1;
    chk("wbrst_pc_inc", 32'(pc_inc), 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("wbrst_alu_en", 32'(alu_en), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("wbrst_reg_we", 32'(reg_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("wbrst_ready", 32'(instr_ready), 32'd1);
    chk("wbrst_reg_we_after", 32'(reg_we), 32'd0);
    chk("wbrst_rd_cleared", 32'(rd_addr), 32'd0);

    // Random instruction stream
    for (int i = 0; i < 60; i++) begin
      ins = 8'($urandom);
      if (ins[7:5] == 3'b111)
        run_hlt(ins, int'($urandom_range(1, 3)));
      else
        run_instr(ins, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    #1;
    chk("final_ready", 32'(instr_ready), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/imm_exec_ctrl.md
Name: imm_exec_ctrl

Overview:
- Multi-cycle control FSM for the 8-bit core.
- Accepts one 8-bit instruction per handshake and decodes it.
- Sequences decode, execute and writeback; drives the 3-bit immediate field to the immediate extender, plus the ALU operand-select, ALU op and register-file write strobes.
- Sits between the instruction-fetch register and the datapath (extender, ALU, register file).

Parameters:
- DATA_W, 8, instruction and datapath width.
- IMM_W, 3, immediate field width fed to the extender.
- RA_W, 2, register-file address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- instr_valid  in  1  instruction byte available.
- instr  in  DATA_W  instruction: [7:5] opcode, [4:3] rd, [2:0] imm/rs (rs = [1:0]).
- instr_ready  out  1  controller can accept an instruction.
- stall  in  1  freezes EXEC/WB progression.
- resume  in  1  leaves HALT.
- pc_inc  out  1  one-cycle pulse on instruction accept.
- imm_field  out  IMM_W  registered immediate to the extender.
- alu_src_imm  out  1  1 = operand B from extender, 0 = register rs.
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 PASS-B.
- alu_en  out  1  one-cycle execute strobe.
- rd_addr  out  RA_W  destination register.
- rs_addr  out  RA_W  source register.
- reg_we  out  1  one-cycle register write strobe.
- halted  out  1  high in HALT.
- imm_sext  out  1  sign-extension request to the extender (see Optional Feature).

Behaviour:
- States: FETCH, DECODE, EXEC, WB, HALT. Reset state is FETCH.
- Reset values: all outputs 0, except instr_ready = 1, which follows FETCH.
- Reset mid-operation aborts the in-flight instruction. No reg_we is issued for it.
- Opcodes:
  - 000 NOP
  - 001 ADD rd,rs
  - 010 SUB rd,rs
  - 011 ADDI rd,imm
  - 100 SUBI rd,imm
  - 101 AND rd,rs
  - 110 LDI rd,imm (PASS-B)
  - 111 HLT
- FETCH:
  - instr_ready = 1.
  - On instr_valid & instr_ready: latch instr, pulse pc_inc, go to DECODE.
  - Without instr_valid: stay in FETCH.
- DECODE (1 cycle): register rd_addr, rs_addr, imm_field, alu_src_imm, alu_op; outputs hold until the next DECODE.
  - NOP goes to FETCH.
  - HLT goes to HALT.
  - All other opcodes go to EXEC.
- EXEC:
  - alu_en = 1 for exactly one cycle, the cycle the FSM leaves EXEC.
  - While stall = 1: stay in EXEC with alu_en = 0.
  - Otherwise go to WB.
- WB:
  - reg_we = 1 for exactly one cycle, the cycle the FSM leaves WB.
  - While stall = 1: hold with reg_we = 0.
  - Then go to FETCH.
- HALT:
  - halted = 1, instr_ready = 0.
  - resume = 1 goes to FETCH next cycle.
  - stall is ignored.
- Latency with no stall: accept at edge N, alu_en at N+2, reg_we at N+3, instr_ready high again at N+4.
- Throughput is one instruction per 4 cycles (NOP: 2 cycles).
- Operand B select: alu_src_imm = 1 for ADDI, SUBI and LDI; 0 otherwise.
- imm_field is instr[2:0] for every opcode; it is only meaningful when alu_src_imm = 1.
- Simultaneous stall and resume in HALT: resume wins.
- instr_valid outside FETCH is ignored; no capture occurs.

Optional Feature:
- Macro: IMM_SIGN_EXT_EN.
- Defined: imm_sext = 1 registered in DECODE for SUBI and ADDI. The extender treats the field as signed (range -4..+3).
- Undefined: imm_sext is tied to 0. The extender zero-extends {5'b00000, imm} for every immediate opcode.

Decomposition:
- Shared package imm_exec_pkg holds:
  - the opcode localparams (OP_NOP..OP_HLT);
  - the ALU op encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_PASSB);
  - the state enum (ST_FETCH..ST_HALT);
  - the instruction field bit positions.
- One sub-module is natural: imm_exec_decode, a combinational opcode-to-control-word decoder whose outputs are registered by the FSM in DECODE.

Test Plan:
- Reset: hold rst_n = 0 for 2 clocks with instr_valid = 1 → no pc_inc; instr_ready = 1 after release; all strobes 0.
- ADDI: instr = 8'b011_10_101 with valid high for 1 cycle → pc_inc at N, imm_field = 3'b101, alu_src_imm = 1, alu_op = 00, alu_en at N+2, reg_we at N+3, rd_addr = 2.
- Stall: ADD rd = 1, rs = 3 (8'b001_01_011) with stall = 1 for 3 cycles during EXEC → alu_en delayed exactly 3 cycles; alu_src_imm = 0, rs_addr = 3; one reg_we only.
- NOP then LDI back-to-back valid → NOP produces no alu_en/reg_we and re-accepts after 2 cycles. LDI 8'b110_00_111 gives alu_op = 11, imm_field = 7, reg_we once.
- HLT: 8'b111_00_000 → halted = 1 and instr_ready = 0 from N+2. instr_valid ignored while halted. resume pulse → FETCH, instr_ready = 1 next cycle.
- Optional feature: SUBI 8'b100_11_100 → imm_sext = 1 with IMM_SIGN_EXT_EN defined, 0 without; alu_op = 01 in both builds. Also assert rst_n low during WB → reg_we never asserts and the FSM returns to FETCH.
